// File: rtl/dm_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_port_arbiter_pkg                                                  |
// | Shared owner encoding and defaults for the data-memory port arbiter. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package dm_port_arbiter_pkg;

  typedef logic [1:0] owner_t;

  localparam owner_t c_OWN_NONE = 2'b00;
  localparam owner_t c_OWN_CPU  = 2'b01;
  localparam owner_t c_OWN_DMA  = 2'b10;

  localparam int c_STARVE_LIMIT = 4;
  localparam int c_DM_AW        = 12;

  localparam int c_CNT_W = 4;

  // DMA writes always cover the whole word.
  localparam logic [3:0] c_BE_FULL = 4'hF;

endpackage : dm_port_arbiter_pkg
`default_nettype wire

// File: rtl/dm_arb_starve_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_arb_starve_cnt                                                    |
// | Saturating count of consecutive denied DMA cycles; raises o_force.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dm_arb_starve_cnt
  import dm_port_arbiter_pkg::*;
#(
  parameter int LIMIT = c_STARVE_LIMIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic               i_gnt,
  output logic               o_force,
  output logic [c_CNT_W-1:0] o_count
);

  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(LIMIT);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_at_limit;

  assign w_at_limit = (r_cnt == c_LIMIT);

  // force depends only on the request and the stored count, never on the
  // grant it produces, so there is no combinational loop through the top.
  assign o_force = i_req && w_at_limit;
  assign o_count = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (!w_at_limit) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

endmodule : dm_arb_starve_cnt
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_port_arbiter                                                      |
// | Shares the single-port DM between the CPU M stage and a DMA master.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int AW           = c_DM_AW,
  parameter int STARVE_LIMIT = c_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [3:0]    cpu_be,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [31:0]   dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [31:0]   dma_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  logic               w_force_dma;
  logic               w_grant_cpu;
  logic               w_grant_dma;
  logic [c_CNT_W-1:0] w_starve_cnt;
  owner_t             r_rd_owner;

  dm_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .rst     (reset),
    .i_req   (dma_req),
    .i_gnt   (w_grant_dma),
    .o_force (w_force_dma),
    .o_count (w_starve_cnt)
  );

  assign w_grant_cpu = cpu_req && !w_force_dma;
  assign w_grant_dma = dma_req && (!cpu_req || w_force_dma);

  assign cpu_stall = cpu_req && !w_grant_cpu;
  assign dma_gnt   = w_grant_dma;

  // Byte-address bits outside the word index are aliased away on purpose.
  always_comb begin
    mem_en    = w_grant_cpu | w_grant_dma;
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_grant_cpu) begin
      mem_addr  = cpu_addr[AW+1:2];
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we ? cpu_be : 4'h0;
    end else if (w_grant_dma) begin
      mem_addr  = dma_addr[AW+1:2];
      mem_wdata = dma_wdata;
      mem_we    = dma_we ? c_BE_FULL : 4'h0;
    end
  end

  // One-deep owner tag lines up with the DM's single-cycle read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_owner <= c_OWN_NONE;
    end else if (w_grant_cpu && !cpu_we) begin
      r_rd_owner <= c_OWN_CPU;
    end else if (w_grant_dma && !dma_we) begin
      r_rd_owner <= c_OWN_DMA;
    end else begin
      r_rd_owner <= c_OWN_NONE;
    end
  end

  assign cpu_rvalid = (r_rd_owner == c_OWN_CPU);
  assign dma_rvalid = (r_rd_owner == c_OWN_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

  logic w_unused;
  assign w_unused = ^{cpu_addr[31:AW+2], cpu_addr[1:0],
                      dma_addr[31:AW+2], dma_addr[1:0], w_starve_cnt};

endmodule : dm_port_arbiter
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dm_port_arbiter                                                   |
// | Directed self-checking bench with a byte-enabled DM model.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_dm_port_arbiter;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [3:0]    cpu_be;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic          cpu_stall, cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          dma_req, dma_we;
  logic [31:0]   dma_addr, dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [31:0]   dma_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.AW(AW), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_be     (cpu_be),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous-read DM with byte write enables.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we != 4'h0) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic cr, input logic cw, input logic [3:0] be,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_be = be; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  // Drive on the falling edge, then sample 1 time unit later.
  task automatic apply(input logic cr, input logic cw, input logic [3:0] be,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    set_in(cr, cw, be, ca, cd, dr, dw, da, dd);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".outs"}, {28'h0, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid}, 32'h0);
    check({tag, ".mem_en"}, 32'(mem_en), 32'h0);
    check({tag, ".mem_we"}, 32'(mem_we), 32'h0);
    check({tag, ".mem_addr"}, 32'(mem_addr), 32'h0);
    check({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    check({tag, ".cpu_rdata"}, cpu_rdata, 32'h0);
    check({tag, ".dma_rdata"}, dma_rdata, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset and idle
    idle();
    check_all_zero("rst");
    reset = 1'b0;
    idle();
    check_all_zero("idle");
    check("idle.cnt", 32'(dut.u_starve_cnt.r_cnt), 32'h0);

    // Preload via DMA full-word writes
    apply(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    check("dwr.gnt", 32'(dma_gnt), 32'h1);
    check("dwr.we", 32'(mem_we), 32'hF);
    check("dwr.addr", 32'(mem_addr), 32'h4);
    check("dwr.wdata", mem_wdata, 32'hDEADBEEF);
    apply(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hAABBCCDD);
    check("dwr2.addr", 32'(mem_addr), 32'h8);
    check("dwr.no_rvalid", 32'(dma_rvalid), 32'h0);

    // Single CPU read
    apply(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("crd.addr", 32'(mem_addr), 32'h4);
    check("crd.en_we", {27'h0, mem_en, mem_we}, 32'h10);
    check("crd.stall", 32'(cpu_stall), 32'h0);
    idle();
    check("crd.rvalid", {30'h0, cpu_rvalid, dma_rvalid}, 32'h2);
    check("crd.rdata", cpu_rdata, 32'hDEADBEEF);

    // Both masters request; DMA forced through on the fifth cycle
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      check($sformatf("stv%0d.cnt", i), 32'(dut.u_starve_cnt.r_cnt), 32'(i));
      check($sformatf("stv%0d.gnt", i), 32'(dma_gnt), (i == 4) ? 32'h1 : 32'h0);
      check($sformatf("stv%0d.stall", i), 32'(cpu_stall), (i == 4) ? 32'h1 : 32'h0);
      check($sformatf("stv%0d.addr", i), 32'(mem_addr), (i == 4) ? 32'h8 : 32'h4);
      if (i > 0) check($sformatf("stv%0d.crv", i), 32'(cpu_rvalid), 32'h1);
    end
    apply(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("stv5.stall_gnt", {30'h0, cpu_stall, dma_gnt}, 32'h0);
    check("stv5.cnt", 32'(dut.u_starve_cnt.r_cnt), 32'h0);
    check("stv5.rvalid", {30'h0, cpu_rvalid, dma_rvalid}, 32'h1);
    check("stv5.drdata", dma_rdata, 32'hAABBCCDD);
    idle();
    check("stv6.crv", 32'(cpu_rvalid), 32'h1);

    // CPU partial store then DMA read of the same word
    apply(1'b1, 1'b1, 4'b0011, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0);
    check("cst.we", 32'(mem_we), 32'h3);
    check("cst.wdata", mem_wdata, 32'h12345678);
    apply(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    check("cst.gnt", 32'(dma_gnt), 32'h1);
    check("cst.no_rvalid", {30'h0, cpu_rvalid, dma_rvalid}, 32'h0);
    idle();
    check("cst.drv", 32'(dma_rvalid), 32'h1);
    check("cst.drdata", dma_rdata, 32'hAABB5678);

    // Alternating CPU / DMA reads, one issued and one returned per cycle
    for (int i = 0; i < 7; i++) begin
      if (i == 6) idle();
      else if (i % 2 == 0) apply(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      else apply(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          check($sformatf("alt%0d.rv", i), {30'h0, cpu_rvalid, dma_rvalid}, 32'h2);
          check($sformatf("alt%0d.cdata", i), cpu_rdata, 32'hDEADBEEF);
        end else begin
          check($sformatf("alt%0d.rv", i), {30'h0, cpu_rvalid, dma_rvalid}, 32'h1);
          check($sformatf("alt%0d.ddata", i), dma_rdata, 32'hAABB5678);
        end
      end
    end

    // Read-after-write on consecutive cycles, aliased address bits ignored
    apply(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h30, 32'h0BADF00D);
    apply(1'b1, 1'b0, 4'hF, 32'hFFFF_C030, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("raw.addr", 32'(mem_addr), 32'hC);
    idle();
    check("raw.rdata", cpu_rdata, 32'h0BADF00D);

    // Reset in the cycle after a CPU read grant
    apply(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_all_zero("mid_rst");
    check("mid_rst.cnt", 32'(dut.u_starve_cnt.r_cnt), 32'h0);
    idle();
    reset = 1'b0;
    idle();
    check("post_rst.rv", {30'h0, cpu_rvalid, dma_rvalid}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_dm_port_arbiter
`default_nettype wire
